// File: rtl/distance_zone_filter.sv
// distance_zone_filter
// Turns raw ultrasonic echo durations (in clk cycles) into a debounced
// distance zone: NONE / CLOSE / IN_RANGE / FAR. Thresholds carry hysteresis
// relative to the committed zone, a zone is committed only after CONFIRM
// consecutive agreeing samples, and the zone falls back to NONE when no echo
// arrives for STALE_CYCLES cycles. All outputs are registered.
module distance_zone_filter #(
  parameter int DUR_W        = 32,
  parameter int MIN_DUR      = 2900,
  parameter int MAX_DUR      = 14500,
  parameter int HYST         = 290,
  parameter int CONFIRM      = 3,
  parameter int STALE_CYCLES = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DUR_W-1:0] echo_duration_i,
  input  logic             echo_valid_i,
  output logic [1:0]       zone_o,
  output logic             present_o,
  output logic             zone_change_o
);

  localparam logic [1:0] ZONE_NONE  = 2'd0;
  localparam logic [1:0] ZONE_CLOSE = 2'd1;
  localparam logic [1:0] ZONE_IN    = 2'd2;
  localparam logic [1:0] ZONE_FAR   = 2'd3;

  localparam int CW = $clog2(CONFIRM + 1);
  localparam int TW = $clog2(STALE_CYCLES + 1);

  // Thresholds are held one bit wider than the duration so that MAX_DUR+HYST
  // can never wrap around and swallow large durations.
  localparam logic [DUR_W:0] MIN_L  = (DUR_W+1)'(MIN_DUR);
  localparam logic [DUR_W:0] MAX_L  = (DUR_W+1)'(MAX_DUR);
  localparam logic [DUR_W:0] HYS_L  = (DUR_W+1)'(HYST);
  localparam logic [DUR_W:0] MIN_LO = MIN_L - HYS_L;
  localparam logic [DUR_W:0] MIN_HI = MIN_L + HYS_L;
  localparam logic [DUR_W:0] MAX_LO = MAX_L - HYS_L;
  localparam logic [DUR_W:0] MAX_HI = MAX_L + HYS_L;

  localparam logic [CW-1:0] CONFIRM_C  = CW'(CONFIRM);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] STALE_C    = TW'(STALE_CYCLES);
  localparam logic [TW-1:0] STALE_LAST = TW'(STALE_CYCLES - 1);

  logic [1:0]    zone_q, zone_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          present_q, present_d;
  logic          change_q, change_d;

  logic [DUR_W:0] d_ext;
  logic [1:0]     raw_cls;
  logic [1:0]     cls;

  assign d_ext = {1'b0, echo_duration_i};

  // Classify the incoming duration, widening the band around the committed zone.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    raw_cls = ZONE_IN;
    cls     = ZONE_IN;
    if (d_ext < MIN_L)      raw_cls = ZONE_CLOSE;
    else if (d_ext > MAX_L) raw_cls = ZONE_FAR;

    case (zone_q)
      ZONE_IN: begin
        if (d_ext < MIN_LO)      cls = ZONE_CLOSE;
        else if (d_ext > MAX_HI) cls = ZONE_FAR;
        else                     cls = ZONE_IN;
      end
      ZONE_CLOSE: cls = (d_ext < MIN_HI) ? ZONE_CLOSE : raw_cls;
      ZONE_FAR:   cls = (d_ext > MAX_LO) ? ZONE_FAR : raw_cls;
      default:    cls = raw_cls;
    endcase
  end

  // Debounce new samples and run the staleness timer; a strobe beats expiry.
  always_comb begin
    zone_d   = zone_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    change_d = 1'b0;

    if (echo_valid_i) begin
      timer_d = '0;
      if (cls == cand_q) begin
        if (cnt_q != CONFIRM_C) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = cls;
        cnt_d  = CNT_ONE;
      end
      if ((cnt_d == CONFIRM_C) && (cand_d != zone_q)) begin
        zone_d   = cand_d;
        change_d = 1'b1;
      end
    end else begin
      if (timer_q != STALE_C) timer_d = timer_q + 1'b1;
      if (timer_q == STALE_LAST) begin
        zone_d   = ZONE_NONE;
        cand_d   = ZONE_NONE;
        cnt_d    = '0;
        change_d = (zone_q != ZONE_NONE);
      end
    end

    present_d = (zone_d == ZONE_IN);
  end

  // State and output registers; reset wins over any sample arriving with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      zone_q    <= ZONE_NONE;
      cand_q    <= ZONE_NONE;
      cnt_q     <= '0;
      timer_q   <= '0;
      present_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      zone_q    <= zone_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      present_q <= present_d;
      change_q  <= change_d;
    end
  end

  assign zone_o        = zone_q;
  assign present_o     = present_q;
  assign zone_change_o = change_q;

endmodule
